// File: rtl/yarvi_trace_buf.sv
// Retirement trace buffer: circular FIFO of retired-instruction records with
// overflow accounting (drop count, gap marker) and a wrapping retire counter.
module yarvi_trace_buf #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  rt_valid,
    input  logic [1:0]            rt_prv,
    input  logic [XLEN-1:0]       rt_pc,
    input  logic [31:0]           rt_insn,
    input  logic [4:0]            rt_rd,
    input  logic [XLEN-1:0]       rt_val,
    input  logic                  rt_trap,

    input  logic                  tr_ready,
    output logic                  tr_valid,
    output logic [3:0]            tr_info,
    output logic [1:0]            tr_prv,
    output logic [XLEN-1:0]       tr_pc,
    output logic [31:0]           tr_insn,
    output logic [4:0]            tr_wb_rd,
    output logic [XLEN-1:0]       tr_wb_val,

    output logic [15:0]           dropped,
    output logic [31:0]           retired,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned REC_W = 3 + 2 + XLEN + 32 + 5 + XLEN;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [REC_W-1:0]       mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic                   gap;

    logic                   full;
    logic                   pop;
    logic                   push;
    logic [4:0]             st_rd;
    logic [XLEN-1:0]        st_val;
    logic [REC_W-1:0]       wr_rec;
    logic [REC_W-1:0]       rd_rec;
    logic                   rd_full;
    logic                   rd_gap;
    logic                   rd_trap;

    assign full     = (level == FULL_LEVEL);
    assign tr_valid = (level != '0);
    assign pop      = tr_valid && tr_ready;
    // A full buffer still accepts a record when the head leaves in the same cycle.
    assign push     = rt_valid && (!full || pop);

    assign st_rd  = rt_trap ? 5'd0 : rt_rd;
    assign st_val = (st_rd != 5'd0) ? rt_val : '0;
    assign wr_rec = {full, gap, rt_trap, rt_prv, rt_pc, rt_insn, st_rd, st_val};

    assign rd_rec = mem[rd_ptr];
    assign {rd_full, rd_gap, rd_trap, tr_prv, tr_pc, tr_insn, tr_wb_rd, tr_wb_val} = rd_rec;
    assign tr_info = tr_valid ? {1'b0, rd_full, rd_gap, rd_trap} : '0;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            gap     <= 1'b0;
            dropped <= '0;
            retired <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (rt_valid) begin
                retired <= retired + 1'b1;
            end
            if (push) begin
                gap <= 1'b0;
            end else if (rt_valid) begin
                gap <= 1'b1;
                if (dropped != '1) begin
                    dropped <= dropped + 1'b1;
                end
            end
        end
    end

endmodule
